// File: rtl/ibt_engine_if.sv
// ibt_engine_if: job, load-stream and drain-stream signals of ibt_engine.
// slave = engine side, master = driver/consumer side.
interface ibt_engine_if #(
    parameter int W = 8
);
    logic         start;
    logic [3:0]   len;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;
    logic         done;

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, done
    );

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/ibt_engine.sv
// ibt_engine: inverts an in-place forward-difference block of up to DEPTH words.
// Ports: clk, rst_n (async, active-low); bus (slave): start/len job request,
// in_valid/in_ready/in_data load stream, out_valid/out_ready/out_data drain
// stream, busy (not IDLE), done (pulse on acceptance of the last word).
module ibt_engine #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    ibt_engine_if.slave  bus
);
    localparam int         AW   = $clog2(DEPTH);
    localparam logic [3:0] LMAX = 4'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, DRAIN} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_len;
    logic [AW-1:0] r_k;
    logic [AW-1:0] r_p;
    logic [AW-1:0] r_i;
    logic [W-1:0]  r_mem [DEPTH];

    logic          w_start_ok;
    logic [3:0]    w_len_sat;
    logic          w_last_k;
    logic          w_calc_end;
    logic [AW-1:0] w_i1;
    logic          w_load_fire;
    logic          w_out_fire;
    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_done;

    assign w_start_ok = bus.start && (bus.len != 4'd0);
    assign w_len_sat  = (bus.len > LMAX) ? LMAX : bus.len;
    assign w_last_k   = (4'(r_k) == (r_len - 4'd1));
    assign w_calc_end = (r_i == '0) && (r_p == AW'(1));
    assign w_i1       = r_i + AW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_done      = 1'b0;
        w_load_fire = 1'b0;
        w_out_fire  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_start_ok) w_next = LOAD;
            end
            LOAD: begin
                w_in_ready  = 1'b1;
                w_load_fire = bus.in_valid;
                if (bus.in_valid && w_last_k)
                    w_next = (r_len > 4'd1) ? CALC : DRAIN;
            end
            CALC: begin
                if (w_calc_end) w_next = DRAIN;
            end
            DRAIN: begin
                w_out_valid = 1'b1;
                w_out_fire  = bus.out_ready;
                if (bus.out_ready && w_last_k) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Inverse walk: pass p from L-1 down to 1, i from L-1-p down to 0.
    // Each pass restarts at i = L-1-(p-1) = L-p.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len <= '0;
            r_k   <= '0;
            r_p   <= '0;
            r_i   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_len <= w_len_sat;
                        r_k   <= '0;
                    end
                end
                LOAD: begin
                    if (w_load_fire) begin
                        if (w_last_k) begin
                            r_k <= '0;
                            r_p <= AW'(r_len - 4'd1);
                            r_i <= '0;
                        end else begin
                            r_k <= r_k + AW'(1);
                        end
                    end
                end
                CALC: begin
                    if (r_i == '0) begin
                        if (!w_calc_end) begin
                            r_p <= r_p - AW'(1);
                            r_i <= AW'(r_len - 4'(r_p));
                        end
                    end else begin
                        r_i <= r_i - AW'(1);
                    end
                end
                DRAIN: begin
                    if (w_out_fire) begin
                        r_k <= w_last_k ? '0 : r_k + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Data store is not reset; every job fully rewrites the words it uses.
    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            r_mem[r_k] <= bus.in_data;
        end else if (r_state == CALC) begin
            r_mem[r_i] <= r_mem[w_i1] - r_mem[r_i];
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = (r_state == DRAIN) ? r_mem[r_k] : '0;
    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = w_done;
endmodule

// File: tb/tb_ibt_engine.sv
// tb_ibt_engine: directed table plus reset and random round-trip sequences
// for ibt_engine.
module tb_ibt_engine;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ibt_engine_if #(.W(W)) bus();

    ibt_engine #(.W(W), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] len;
        int         nl;
        int         ncalc;
        bit         bp;
        logic [7:0] din  [8];
        logic [7:0] dexp [8];
    } rec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the engine idle.
    task automatic run_job(input rec_t r, input bit stress);
        int k;
        int calc;
        int guard;
        int dones;
        int donek;
        bit stalled;
        logic [W-1:0] held;
        bus.start = 1'b1;
        bus.len   = r.len;
        @(negedge clk);
        bus.start = 1'b0;
        bus.len   = 4'd0;
        chk("load_busy", 32'(bus.busy), 1);
        chk("load_in_ready", 32'(bus.in_ready), 1);
        k = 0;
        guard = 0;
        while (k < r.nl && guard < 400) begin
            bus.in_valid = stress ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.in_data  = r.din[k];
            #1;
            if (bus.in_valid && bus.in_ready) k++;
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        chk("load_count", k, r.nl);
        calc = 0;
        while (bus.busy && !bus.out_valid && guard < 400) begin
            if (stress) begin
                bus.start = 1'b1;
                bus.len   = 4'd2;
            end
            chk("calc_in_ready", 32'(bus.in_ready), 0);
            calc++;
            @(negedge clk);
            guard++;
        end
        bus.start = 1'b0;
        bus.len   = 4'd0;
        chk("calc_cycles", calc, r.ncalc);
        k = 0;
        dones = 0;
        donek = -1;
        stalled = 1'b0;
        held = '0;
        while (k < r.nl && guard < 400) begin
            bus.out_ready = stress ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            chk("out_valid", 32'(bus.out_valid), 1);
            chk("out_data", 32'(bus.out_data), 32'(r.dexp[k]));
            if (stalled) chk("stall_hold", 32'(bus.out_data), 32'(held));
            if (bus.done) begin
                dones++;
                donek = k;
            end
            stalled = !bus.out_ready;
            held = bus.out_data;
            if (bus.out_ready) k++;
            @(negedge clk);
            guard++;
        end
        bus.out_ready = 1'b0;
        chk("drain_count", k, r.nl);
        chk("done_pulses", dones, 1);
        chk("done_index", donek, r.nl - 1);
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_out_valid", 32'(bus.out_valid), 0);
        chk("idle_done", 32'(bus.done), 0);
    endtask

    rec_t vec [7];
    rec_t rr;
    int   L;

    initial begin
        #50_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus.start     = 1'b0;
        bus.len       = 4'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        vec[0].len = 4'd4; vec[0].nl = 4; vec[0].ncalc = 6; vec[0].bp = 0;
        vec[0].din  = '{106, 125, 160, 220, 0, 0, 0, 0};
        vec[0].dexp = '{9, 25, 60, 220, 0, 0, 0, 0};
        vec[1].len = 4'd2; vec[1].nl = 2; vec[1].ncalc = 1; vec[1].bp = 0;
        vec[1].din  = '{250, 5, 0, 0, 0, 0, 0, 0};
        vec[1].dexp = '{11, 5, 0, 0, 0, 0, 0, 0};
        vec[2].len = 4'd1; vec[2].nl = 1; vec[2].ncalc = 0; vec[2].bp = 0;
        vec[2].din  = '{77, 0, 0, 0, 0, 0, 0, 0};
        vec[2].dexp = '{77, 0, 0, 0, 0, 0, 0, 0};
        vec[3].len = 4'd12; vec[3].nl = 8; vec[3].ncalc = 28; vec[3].bp = 0;
        vec[3].din  = '{0, 0, 0, 0, 0, 0, 1, 7};
        vec[3].dexp = '{0, 1, 2, 3, 4, 5, 6, 7};
        vec[4].len = 4'd3; vec[4].nl = 3; vec[4].ncalc = 3; vec[4].bp = 0;
        vec[4].din  = '{10, 30, 100, 0, 0, 0, 0, 0};
        vec[4].dexp = '{50, 70, 100, 0, 0, 0, 0, 0};
        vec[5] = vec[0];
        vec[5].bp = 1;
        vec[6] = vec[3];
        vec[6].len = 4'd8;
        vec[6].bp = 1;

        #12;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            run_job(vec[v], vec[v].bp);
        end

        bus.start = 1'b1;
        bus.len   = 4'd0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("len0_busy", 32'(bus.busy), 0);
        chk("len0_in_ready", 32'(bus.in_ready), 0);

        bus.start = 1'b1;
        bus.len   = 4'd4;
        @(negedge clk);
        bus.start = 1'b0;
        bus.len   = 4'd0;
        for (int j = 0; j < 4; j++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vec[0].din[j];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_calc_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_in_ready", 32'(bus.in_ready), 0);
        chk("abort_out_valid", 32'(bus.out_valid), 0);
        chk("abort_out_data", 32'(bus.out_data), 0);
        @(negedge clk);
        chk("abort_done_hold", 32'(bus.done), 0);
        rst_n = 1'b1;
        run_job(vec[0], 1'b0);

        for (int n = 0; n < 1000; n++) begin
            L = $urandom_range(1, 8);
            rr.len   = (L == 8) ? 4'($urandom_range(8, 15)) : 4'(L);
            rr.nl    = L;
            rr.ncalc = L * (L - 1) / 2;
            rr.bp    = n[0];
            for (int j = 0; j < 8; j++) begin
                rr.dexp[j] = (j < L) ? 8'($urandom) : 8'd0;
                rr.din[j]  = rr.dexp[j];
            end
            for (int p = 1; p < L; p++) begin
                for (int i = 0; i <= L - 1 - p; i++) begin
                    rr.din[i] = rr.din[i + 1] - rr.din[i];
                end
            end
            run_job(rr, rr.bp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
